// File: rtl/gated_block_retention_model.sv
// Behavioural model of a power-gated block with state retention: a live register,
// a retention copy, save/restore four-phase handshakes and a sticky protocol-error flag.
module gated_block_retention_model #(
  parameter int                 DATA_W      = 32,
  parameter int                 SAVE_LAT    = 2,
  parameter int                 RESTORE_LAT = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
  parameter logic [31:0]        POISON      = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pwr_on_i,
  input  logic              save_req_i,
  input  logic              restore_req_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] live_data_o,
  output logic              save_ack_o,
  output logic              restore_ack_o,
  output logic              retained_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [DATA_W-1:0] POISON_W    = DATA_W'(POISON);
  localparam logic [3:0]        SAVE_END    = 4'(SAVE_LAT - 1);
  localparam logic [3:0]        RESTORE_END = 4'(RESTORE_LAT - 1);

  typedef enum logic [2:0] {IDLE, SAVING, SAVE_ACK, RESTORING, RESTORE_ACK} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] live_q, live_d;
  logic [DATA_W-1:0] ret_q, ret_d;
  logic              retained_q, retained_d;
  logic              save_ack_q, save_ack_d;
  logic              restore_ack_q, restore_ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              pwr_q;
  logic              viol;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    live_d        = live_q;
    ret_d         = ret_q;
    retained_d    = retained_q;
    save_ack_d    = save_ack_q;
    restore_ack_d = restore_ack_q;
    viol          = 1'b0;

    if (!pwr_on_i) begin
      live_d = POISON_W;
      // Power just dropped: any in-flight operation is lost and the handshake is torn down.
      if (pwr_q) begin
        if (!retained_q) viol = 1'b1;
        if (state_q == SAVING || state_q == RESTORING) viol = 1'b1;
        state_d       = IDLE;
        cnt_d         = '0;
        save_ack_d    = 1'b0;
        restore_ack_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_en_i) live_d = wr_data_i;
          if (save_req_i) begin
            state_d = SAVING;
            cnt_d   = '0;
          end else if (restore_req_i) begin
            state_d = RESTORING;
            cnt_d   = '0;
          end
        end
        SAVING: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SAVE_END) begin
            ret_d      = live_q;
            retained_d = 1'b1;
            save_ack_d = 1'b1;
            state_d    = SAVE_ACK;
          end
        end
        SAVE_ACK: begin
          if (wr_en_i) live_d = wr_data_i;
          if (!save_req_i) begin
            save_ack_d = 1'b0;
            state_d    = IDLE;
          end
        end
        RESTORING: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == RESTORE_END) begin
            if (retained_q) live_d = ret_q;
            else            viol   = 1'b1;
            retained_d    = 1'b0;
            restore_ack_d = 1'b1;
            state_d       = RESTORE_ACK;
          end
        end
        RESTORE_ACK: begin
          if (wr_en_i) live_d = wr_data_i;
          if (!restore_req_i) begin
            restore_ack_d = 1'b0;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    err_d = err_clr_i ? 1'b0 : err_q;
    if (viol) err_d = 1'b1;
    busy_d = (state_d == SAVING) || (state_d == RESTORING);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      live_q        <= RESET_VAL;
      ret_q         <= '0;
      retained_q    <= 1'b0;
      save_ack_q    <= 1'b0;
      restore_ack_q <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      pwr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      live_q        <= live_d;
      ret_q         <= ret_d;
      retained_q    <= retained_d;
      save_ack_q    <= save_ack_d;
      restore_ack_q <= restore_ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      pwr_q         <= pwr_on_i;
    end
  end

  assign live_data_o   = live_q;
  assign save_ack_o    = save_ack_q;
  assign restore_ack_o = restore_ack_q;
  assign retained_o    = retained_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_gated_block_retention_model.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level model (operation + countdown) of the retention block.
module tb_gated_block_retention_model;
  localparam int          DW = 32;
  localparam int          SL = 2;
  localparam int          RL = 3;
  localparam logic [31:0] PZ = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst, pwr_on, save_req, restore_req, wr_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] live_data;
  logic          save_ack, restore_ack, retained, busy, err;

  int checks   = 0;
  int failures = 0;

  // Reference model: op 0=none 1=save 2=restore, left = cycles to completion.
  logic [DW-1:0] m_live, m_ret;
  logic          m_retained, m_sack, m_rack, m_err, m_prev;
  int            m_op, m_left;

  gated_block_retention_model #(
    .DATA_W(DW), .SAVE_LAT(SL), .RESTORE_LAT(RL), .RESET_VAL('0), .POISON(PZ)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pwr_on_i(pwr_on), .save_req_i(save_req),
    .restore_req_i(restore_req), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .err_clr_i(err_clr), .live_data_o(live_data), .save_ack_o(save_ack),
    .restore_ack_o(restore_ack), .retained_o(retained), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model();
    bit viol;
    viol = 1'b0;
    if (rst) begin
      m_live = '0; m_ret = '0; m_retained = 0; m_sack = 0; m_rack = 0;
      m_err = 0; m_op = 0; m_left = 0; m_prev = 0;
      return;
    end
    if (!pwr_on) begin
      m_live = PZ;
      if (m_prev) begin
        if (!m_retained) viol = 1'b1;
        if (m_op != 0)   viol = 1'b1;
        m_op = 0; m_sack = 0; m_rack = 0;
      end
    end else if (m_op != 0) begin
      if (m_left == 1) begin
        if (m_op == 1) begin
          m_ret = m_live; m_retained = 1; m_sack = 1;
        end else begin
          if (m_retained) m_live = m_ret;
          else            viol = 1'b1;
          m_retained = 0; m_rack = 1;
        end
        m_op = 0;
      end else m_left--;
    end else begin
      if (wr_en) m_live = wr_data;
      if (m_sack)           begin if (!save_req) m_sack = 0; end
      else if (m_rack)      begin if (!restore_req) m_rack = 0; end
      else if (save_req)    begin m_op = 1; m_left = SL; end
      else if (restore_req) begin m_op = 2; m_left = RL; end
    end
    if (err_clr) m_err = 0;
    if (viol)    m_err = 1;
    m_prev = pwr_on;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("live_data", live_data, m_live);
    chk("save_ack", 32'(save_ack), 32'(m_sack));
    chk("restore_ack", 32'(restore_ack), 32'(m_rack));
    chk("retained", 32'(retained), 32'(m_retained));
    chk("busy", 32'(busy), 32'(m_op != 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    rst = 1; pwr_on = 1; save_req = 0; restore_req = 0; wr_en = 0; err_clr = 0; wr_data = '0;
    step(); step();
    chk("rst_live", live_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 0;

    // Save handshake with latency SL
    wr_en = 1; wr_data = 32'h1234_5678; step();
    wr_en = 0; save_req = 1; step();
    chk("s1_busy", 32'(busy), 32'h1);
    step();
    chk("s1_ack_early", 32'(save_ack), 32'h0);
    step();
    chk("s1_ack", 32'(save_ack), 32'h1);
    chk("s1_retained", 32'(retained), 32'h1);
    save_req = 0; step();
    chk("s1_ack_drop", 32'(save_ack), 32'h0);

    // Power cycle with valid retention, then restore
    pwr_on = 0; step();
    chk("s2_poison", live_data, PZ);
    chk("s2_err", 32'(err), 32'h0);
    pwr_on = 1; step();
    restore_req = 1; step(); step(); step();
    chk("s2_rack_early", 32'(restore_ack), 32'h0);
    step();
    chk("s2_rack", 32'(restore_ack), 32'h1);
    chk("s2_live", live_data, 32'h1234_5678);
    chk("s2_retained", 32'(retained), 32'h0);
    restore_req = 0; step();

    // Power-off without a save
    rst = 1; step(); rst = 0;
    wr_en = 1; wr_data = 32'hA5A5_A5A5; step(); wr_en = 0;
    pwr_on = 0; step();
    chk("s3_err", 32'(err), 32'h1);
    chk("s3_poison", live_data, PZ);
    pwr_on = 1; err_clr = 1; step(); err_clr = 0;
    chk("s3_clr", 32'(err), 32'h0);

    // Restore with nothing retained
    wr_en = 1; wr_data = 32'h0BAD_F00D; step(); wr_en = 0;
    restore_req = 1; step(); step(); step(); step();
    chk("s4_rack", 32'(restore_ack), 32'h1);
    chk("s4_live", live_data, 32'h0BAD_F00D);
    chk("s4_err", 32'(err), 32'h1);
    restore_req = 0; step();
    err_clr = 1; step(); err_clr = 0;

    // Power loss mid-save, then reset mid-restore
    save_req = 1; step();
    pwr_on = 0; step();
    chk("s5_sack", 32'(save_ack), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_err", 32'(err), 32'h1);
    chk("s5_retained", 32'(retained), 32'h0);
    save_req = 0; pwr_on = 1; err_clr = 1; step(); err_clr = 0;
    restore_req = 1; step(); step();
    rst = 1; step();
    chk("s5_rst_live", live_data, 32'h0);
    chk("s5_rst_busy", 32'(busy), 32'h0);
    chk("s5_rst_rack", 32'(restore_ack), 32'h0);
    rst = 0; restore_req = 0; step();

    // Simultaneous requests; write during SAVING is ignored
    wr_en = 1; wr_data = 32'h1111_2222; step();
    wr_en = 0; save_req = 1; restore_req = 1; step();
    wr_en = 1; wr_data = 32'h3333_4444; step();
    chk("s6_frozen", live_data, 32'h1111_2222);
    step();
    chk("s6_sack", 32'(save_ack), 32'h1);
    chk("s6_rack", 32'(restore_ack), 32'h0);
    wr_en = 0; save_req = 0; restore_req = 0; step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom % 64) == 0;
      pwr_on      = ($urandom % 12) != 0;
      if (($urandom % 4) == 0) save_req = ~save_req;
      if (($urandom % 4) == 0) restore_req = ~restore_req;
      wr_en       = ($urandom % 3) == 0;
      wr_data     = $urandom;
      err_clr     = ($urandom % 8) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gated_block_retention_model.md
Name: gated_block_retention_model

Overview:
Parametrised behavioural model of a power-gated block with state retention, used as the controlled load in power-gating controller benches. It holds a DATA_W-bit live state register. It answers save and restore requests through a four-phase handshake with programmable latency. It corrupts live state when power is removed and flags protocol violations such as power-off without a valid save.

Parameters:
DATA_W, 32, width of live and retention state
SAVE_LAT, 2, cycles from save_req sampled high to save_ack high (1..15)
RESTORE_LAT, 3, cycles from restore_req sampled high to restore_ack high (1..15)
RESET_VAL, 0, live_data value after reset
POISON, 32'hDEAD_BEEF, value forced into live_data while power is off (truncated or zero-extended to DATA_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pwr_on  in  1  power switch status; 1 = block powered
save_req  in  1  level request to save; held until save_ack is seen
restore_req  in  1  level request to restore; held until restore_ack is seen
wr_en  in  1  functional write strobe to live state
wr_data  in  DATA_W  functional write data
err_clr  in  1  clears err
live_data  out  DATA_W  current live state
save_ack  out  1  save handshake acknowledge
restore_ack  out  1  restore handshake acknowledge
retained  out  1  retention register holds a valid copy
busy  out  1  high in SAVING or RESTORING
err  out  1  sticky protocol-violation flag

Behaviour:
- One clock, synchronous active-high reset. rst dominates all other inputs.
- Reset values: live_data=RESET_VAL; retention reg=0; retained=0; save_ack=0; restore_ack=0; err=0; busy=0; state=IDLE; counter=0. Reset mid-save or mid-restore aborts the operation and emits no ack.
- FSM states: IDLE, SAVING, SAVE_ACK, RESTORING, RESTORE_ACK. Internal counter width is 4 bits.
- IDLE:
  - save_req=1 and pwr_on=1: go to SAVING, counter=0.
  - Otherwise restore_req=1 and pwr_on=1: go to RESTORING, counter=0.
  - Both requests high: save wins; err unaffected.
- SAVING:
  - Counter increments each cycle.
  - On the cycle counter==SAVE_LAT-1: retention reg<=live_data, retained<=1, save_ack<=1, go to SAVE_ACK.
  - save_ack is therefore first high SAVE_LAT cycles after the edge that sampled save_req in IDLE.
- SAVE_ACK: save_ack stays 1 while save_req=1. When save_req=0 is sampled: save_ack<=0, go to IDLE.
- RESTORING:
  - On counter==RESTORE_LAT-1: if retained=1, live_data<=retention reg; if retained=0, live_data is unchanged and err<=1.
  - Same cycle: retained<=0, restore_ack<=1, go to RESTORE_ACK.
- RESTORE_ACK: mirrors SAVE_ACK using restore_req and restore_ack.
- Request dropped before ack (in SAVING or RESTORING): operation still completes and acks. The ack then deasserts on the next cycle because req=0.
- Writes: wr_en=1 with pwr_on=1 in IDLE, SAVE_ACK or RESTORE_ACK loads live_data<=wr_data. Writes in SAVING or RESTORING are ignored; state is frozen.
- Power off (pwr_on=0): live_data<=POISON every cycle; writes ignored; new requests ignored.
- Falling edge of pwr_on (pwr_on=0 sampled after pwr_on=1):
  - retained=0: err<=1.
  - State SAVING: abort to IDLE, no ack, err<=1, retained unchanged.
  - State RESTORING: abort to IDLE, no ack, err<=1; retained and retention reg are kept.
  - State SAVE_ACK or RESTORE_ACK: ack forced to 0, go to IDLE.
- Retention reg and retained survive pwr_on=0. They are lost only on rst or a completed restore.
- err_clr=1 clears err. A violation in the same cycle wins, leaving err=1.
- busy is a registered decode: 1 exactly when state is SAVING or RESTORING.

Test Plan:
1. Default params: write 32'h1234_5678 → assert save_req → save_ack=1 exactly 2 cycles later, retained=1. Drop save_req → save_ack=0 next cycle.
2. After scenario 1, drop pwr_on → live_data=32'hDEAD_BEEF next cycle, err=0. Raise pwr_on, assert restore_req → restore_ack after 3 cycles, live_data=32'h1234_5678, retained=0.
3. Reset, write 32'hA5A5_A5A5, drop pwr_on without save → err=1, live_data=POISON. Pulse err_clr → err=0.
4. restore_req with retained=0 → restore_ack after RESTORE_LAT, live_data unchanged, err=1.
5. Drop pwr_on one cycle into SAVING → no save_ack, retained=0, err=1, state IDLE. Separately, assert rst mid-RESTORING → all outputs at reset values.
6. save_req and restore_req high in the same cycle from IDLE → save path taken, restore_ack stays 0. Assert wr_en during SAVING → live_data unchanged.
